// File: rtl/div_seq.sv
// Bit-serial restoring divider for DIV/DIVU: result ready WIDTH+1 edges after acceptance (2 for a zero divisor).
// Result is held in END while start_i stays high; END is left as soon as start_i drops or annul_i is raised.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
  } work_t;

  state_t           state;
  state_t           state_nxt;
  work_t            work;
  work_t            step;
  work_t            fixed;
  logic [WIDTH-1:0] divisor;
  logic [CNT_W-1:0] cnt;
  logic             neg_quot;
  logic             neg_rem;
  logic             accept;
  logic             last_iter;
  logic             div_zero;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  assign accept    = start_i & ~annul_i;
  assign div_zero  = (opdata2_i == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Magnitudes of the operands; the most negative value maps onto itself, which is correct as unsigned.
  always_comb begin
    op1_mag = (signed_i & opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_mag = (signed_i & opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // One restoring step: bit WIDTH of the difference set means the trial subtraction went negative.
  always_comb begin
    trial      = {work.rem, work.quot[WIDTH-1]};
    diff       = trial - {1'b0, divisor};
    step.quot  = {work.quot[WIDTH-2:0], ~diff[WIDTH]};
    step.rem   = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    fixed.quot = neg_quot ? (~step.quot + 1'b1) : step.quot;
    fixed.rem  = neg_rem  ? (~step.rem + 1'b1)  : step.rem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = div_zero ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        state_nxt = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          state_nxt = S_IDLE;
        end else if (last_iter) begin
          state_nxt = S_END;
        end
      end
      S_END: begin
        if (!start_i || annul_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state == S_END);
    busy_o   = (state != S_IDLE);
    result_o = ready_o ? work : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work     <= '0;
      divisor  <= '0;
      cnt      <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            work.rem  <= '0;
            work.quot <= div_zero ? '0 : op1_mag;
            divisor   <= op2_mag;
            cnt       <= '0;
            neg_quot  <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem   <= signed_i & opdata1_i[WIDTH-1];
          end
        end
        S_DIVZERO: begin
          work <= '0;
        end
        S_ON: begin
          if (!annul_i) begin
            work <= last_iter ? fixed : step;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
